// File: rtl/block_config_loader.sv
`default_nettype none
// ============================================================================
// block_config_loader : packs a word stream into MEM_SIZE-bit config images
//                       and pulses a one-hot enable per block, in order.
// Revision 1.0
// ============================================================================
module block_config_loader #(
   parameter int NUM_BLOCKS = 4,
   parameter int MEM_SIZE   = 16,
   parameter int WORD_BITS  = 8
) (
   input  logic                  cclk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_BITS-1:0]  in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [MEM_SIZE-1:0]   config_out,
   output logic [NUM_BLOCKS-1:0] cen,
   output logic                  busy,
   output logic                  done
);

   localparam int WORDS_PER_BLOCK = MEM_SIZE / WORD_BITS;
   localparam int CNT_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
   localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [IDX_W-1:0] LAST_BLOCK = IDX_W'(NUM_BLOCKS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] word_cnt;
   logic [IDX_W-1:0] block_idx;

   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         word_cnt   <= '0;
         block_idx  <= '0;
         config_out <= '0;
         cen        <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         // cen is a single-cycle pulse; only the last-word transfer raises it
         cen <= '0;
         if (abort) begin
            state     <= IDLE;
            word_cnt  <= '0;
            block_idx <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (start) begin
                     state     <= SHIFT;
                     word_cnt  <= '0;
                     block_idx <= '0;
                     in_ready  <= 1'b1;
                     busy      <= 1'b1;
                     done      <= 1'b0;
                  end
               end
               SHIFT: begin
                  if (in_valid && in_ready) begin
                     for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
                        if (word_cnt == CNT_W'(k))
                           config_out[k*WORD_BITS +: WORD_BITS] <= in_data;
                     end
                     if (word_cnt == LAST_WORD) begin
                        state    <= COMMIT;
                        in_ready <= 1'b0;
                        for (int i = 0; i < NUM_BLOCKS; i++)
                           cen[i] <= (block_idx == IDX_W'(i));
                     end else begin
                        word_cnt <= word_cnt + 1'b1;
                     end
                  end
               end
               COMMIT: begin
                  if (block_idx == LAST_BLOCK) begin
                     state    <= DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     in_ready <= 1'b0;
                  end else begin
                     state     <= SHIFT;
                     block_idx <= block_idx + 1'b1;
                     word_cnt  <= '0;
                     in_ready  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_block_config_loader.sv
`default_nettype none
// ============================================================================
// tb_block_config_loader : randomized + directed bench with a word-count model
// Revision 1.0
// ============================================================================
module tb_block_config_loader;

   localparam int NB    = 4;
   localparam int WPB   = 2;
   localparam int TOTAL = NB * WPB;

   logic        cclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, abort = 1'b0, in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, busy, done;
   logic [15:0] config_out;
   logic [3:0]  cen;

   logic        c_start = 1'b0, c_abort = 1'b0, c_valid = 1'b0;
   logic [7:0]  c_data = 8'h00;
   logic        c_ready, c_busy, c_done;
   logic [7:0]  c_cfg;
   logic [0:0]  c_cen;

   always #5 cclk = ~cclk;

   block_config_loader #(.NUM_BLOCKS(4), .MEM_SIZE(16), .WORD_BITS(8)) dut (
      .cclk(cclk), .rst_n(rst_n), .start(start), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .config_out(config_out), .cen(cen), .busy(busy), .done(done));

   block_config_loader #(.NUM_BLOCKS(1), .MEM_SIZE(8), .WORD_BITS(8)) dut_small (
      .cclk(cclk), .rst_n(rst_n), .start(c_start), .abort(c_abort),
      .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
      .config_out(c_cfg), .cen(c_cen), .busy(c_busy), .done(c_done));

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Session model: counts accepted words; images are the slices they land in
   logic        m_active, m_finished, m_pending;
   int          m_n;
   logic [15:0] m_img;
   logic [19:0] commits[$];

   logic [7:0]  words [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
   logic [15:0] imgs  [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

   function automatic logic m_ready();
      return m_active && !m_pending;
   endfunction

   function automatic logic [3:0] m_cen();
      return m_pending ? 4'(1 << ((m_n - 1) / WPB)) : 4'h0;
   endfunction

   task automatic model_reset();
      m_active = 0; m_finished = 0; m_pending = 0; m_n = 0; m_img = '0;
   endtask

   task automatic model_update();
      if (abort) begin
         m_active = 0; m_finished = 0; m_pending = 0; m_n = 0;
      end else if (m_pending) begin
         m_pending = 0;
         if (m_n == TOTAL) begin
            m_active = 0; m_finished = 1;
         end
      end else if (m_active) begin
         if (in_valid) begin
            m_img[(m_n % WPB)*8 +: 8] = in_data;
            m_n++;
            if (m_n % WPB == 0) m_pending = 1;
         end
      end else if (start) begin
         m_active = 1; m_finished = 0; m_n = 0;
      end
   endtask

   task automatic step();
      @(posedge cclk);
      #1;
      if (!rst_n) model_reset();
      else        model_update();
      if (cen != '0) commits.push_back({cen, config_out});
      check_value("cen", 32'(cen), 32'(m_cen()));
      check_value("in_ready", 32'(in_ready), 32'(m_ready()));
      check_value("busy", 32'(busy), 32'(m_active));
      check_value("done", 32'(done), 32'(m_finished));
      check_value("config_out", 32'(config_out), 32'(m_img));
   endtask

   task automatic feed(input int count, input logic [3:0] pat);
      int wi = 0;
      int cyc = 0;
      logic acc;
      while (wi < count && cyc < 200) begin
         in_valid = pat[cyc % 4];
         in_data  = in_valid ? words[wi] : 8'($urandom);
         acc = in_valid && m_ready();
         step();
         if (acc) wi++;
         cyc++;
      end
      in_valid = 1'b0;
      check_value("feed_complete", 32'(wi), 32'(count));
   endtask

   task automatic check_commits(input string tag);
      check_value({tag, "_count"}, 32'(commits.size()), 32'd4);
      for (int b = 0; b < 4; b++) begin
         if (b < commits.size()) begin
            check_value({tag, "_cen"}, 32'(commits[b][19:16]), 32'(1 << b));
            check_value({tag, "_img"}, 32'(commits[b][15:0]), 32'(imgs[b]));
         end
      end
      commits.delete();
   endtask

   task automatic check_first_commit(input string tag, input int exp_count);
      check_value({tag, "_count"}, 32'(commits.size()), 32'(exp_count));
      if (commits.size() > 0)
         check_value({tag, "_entry"}, 32'(commits[commits.size()-1]), 32'({4'b0001, 16'h1234}));
      commits.delete();
   endtask

   initial begin
      model_reset();
      #12;
      check_value("rst_cen", 32'(cen), 32'd0);
      check_value("rst_ready", 32'(in_ready), 32'd0);
      check_value("rst_busy", 32'(busy), 32'd0);
      check_value("rst_done", 32'(done), 32'd0);
      check_value("rst_cfg", 32'(config_out), 32'd0);
      @(posedge cclk); #1;
      rst_n = 1'b1;
      step();

      // basic load, continuous valid
      commits.delete();
      start = 1'b1; step(); start = 1'b0;
      feed(8, 4'b1111);
      step(); step();
      check_value("basic_done", 32'(done), 32'd1);
      check_commits("basic");

      // backpressure with valid pattern 1,0,0,1 (restart from DONE)
      start = 1'b1; step(); start = 1'b0;
      feed(8, 4'b1001);
      step(); step();
      check_commits("gaps");

      // abort mid-block
      start = 1'b1; step(); start = 1'b0;
      in_valid = 1'b1; in_data = 8'hAA; step(); in_valid = 1'b0;
      abort = 1'b1; step(); abort = 1'b0;
      check_value("abort_busy", 32'(busy), 32'd0);
      check_value("abort_done", 32'(done), 32'd0);
      step();
      check_value("abort_no_cen", 32'(commits.size()), 32'd0);
      start = 1'b1; step(); start = 1'b0;
      feed(2, 4'b1111);
      step();
      check_first_commit("after_abort", 1);
      abort = 1'b1; step(); abort = 1'b0;

      // async reset during SHIFT of block 2
      start = 1'b1; step(); start = 1'b0;
      feed(5, 4'b1111);
      rst_n = 1'b0;
      #1;
      check_value("arst_cen", 32'(cen), 32'd0);
      check_value("arst_ready", 32'(in_ready), 32'd0);
      check_value("arst_busy", 32'(busy), 32'd0);
      check_value("arst_cfg", 32'(config_out), 32'd0);
      model_reset();
      step();
      rst_n = 1'b1;
      step();
      check_value("arst_commits", 32'(commits.size()), 32'd2);
      commits.delete();
      start = 1'b1; step(); start = 1'b0;
      feed(2, 4'b1111);
      step();
      check_first_commit("after_rst", 1);
      abort = 1'b1; step(); abort = 1'b0;

      // start held high through a whole session, then restart from DONE
      start = 1'b1; step();
      feed(8, 4'b1111);
      start = 1'b0;
      step(); step();
      check_commits("start_held");
      start = 1'b1; step(); start = 1'b0;
      check_value("restart_done_clr", 32'(done), 32'd0);
      feed(2, 4'b1111);
      step();
      check_first_commit("restart", 1);
      start = 1'b1; abort = 1'b1; step();
      start = 1'b0; abort = 1'b0;
      check_value("start_abort_idle", 32'(busy), 32'd0);
      step();
      check_value("start_abort_ready", 32'(in_ready), 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         start    = ($urandom % 8) == 0;
         abort    = ($urandom % 60) == 0;
         in_valid = ($urandom % 3) != 0;
         in_data  = 8'($urandom);
         step();
      end
      start = 1'b0; abort = 1'b1; in_valid = 1'b0; step(); abort = 1'b0;
      commits.delete();

      // single-block, single-word configuration
      c_start = 1'b1; step(); c_start = 1'b0;
      check_value("small_ready", 32'(c_ready), 32'd1);
      check_value("small_busy", 32'(c_busy), 32'd1);
      c_valid = 1'b1; c_data = 8'h5A; step(); c_valid = 1'b0;
      check_value("small_cen", 32'(c_cen), 32'd1);
      check_value("small_cfg", 32'(c_cfg), 32'h5A);
      check_value("small_commit_ready", 32'(c_ready), 32'd0);
      step();
      check_value("small_done", 32'(c_done), 32'd1);
      check_value("small_cen_off", 32'(c_cen), 32'd0);
      check_value("small_cfg_hold", 32'(c_cfg), 32'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/block_config_loader.md
Name: block_config_loader

Overview:
Configuration sequencer for a bank of NUM_BLOCKS block-style config SRAMs on the configuration clock domain. It accepts a narrow word stream over a valid/ready handshake, assembles each MEM_SIZE-bit image, and drives the shared parallel config bus. It then pulses the one-hot enable of the target block for exactly one cycle. Blocks are loaded in order 0..NUM_BLOCKS-1 per load session.

Parameters:
NUM_BLOCKS, 4, number of config SRAMs driven; must be >= 1
MEM_SIZE, 16, bits per config SRAM image (2**ADDR_BITS of the target SRAM)
WORD_BITS, 8, width of incoming config word; MEM_SIZE must be an integer multiple of WORD_BITS
WORDS_PER_BLOCK, MEM_SIZE/WORD_BITS, derived; not overridden

Ports:
cclk  input  1  configuration clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a load session; sampled only in IDLE or DONE
abort  input  1  synchronous abort; return to IDLE, no further cen pulses
in_data  input  WORD_BITS  config word
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts word this cycle
config_out  output  MEM_SIZE  shared config bus to every SRAM config_in
cen  output  NUM_BLOCKS  one-hot config enable; bit i drives block i
busy  output  1  session in progress (SHIFT or COMMIT)
done  output  1  all NUM_BLOCKS images committed; held until next start/abort

Behaviour:
- Reset (rst_n low, async): state=IDLE; config_out=0, cen=0, in_ready=0, busy=0, done=0; word counter and block index = 0.
- States: IDLE, SHIFT, COMMIT, DONE.
- IDLE: start=1 -> SHIFT next cycle; clear block index and word counter; done=0.
- SHIFT: in_ready=1, busy=1. Transfer occurs when in_valid && in_ready. Word k (k=0..WORDS_PER_BLOCK-1) is written into config_out[k*WORD_BITS +: WORD_BITS], so the first word is the LSBs. The word counter increments per transfer. On the transfer with k=WORDS_PER_BLOCK-1 -> COMMIT. If in_valid is low, state and counters hold.
- COMMIT: exactly one cycle. cen = 1<<block_idx, in_ready=0, busy=1. config_out is stable for the whole cycle and equals the assembled image. Next state:
  - if block_idx==NUM_BLOCKS-1 -> DONE;
  - otherwise block_idx+1, word counter=0, -> SHIFT.
- Registered outputs: cen is high only in COMMIT and is never multi-hot. Latency from the accepting edge of the last word to the cen-high cycle is 1 cycle.
- DONE: done=1, busy=0, in_ready=0, cen=0. config_out holds the last image. start=1 -> SHIFT (done cleared, indices reset). Otherwise hold.
- start while busy: ignored.
- abort: highest priority in every state. Next state is IDLE; counters cleared; done=0; cen=0 in the following cycle. An abort in COMMIT still lets that cycle's cen pulse complete, because cen is registered. A partial image is never committed.
- Simultaneous start+abort in IDLE/DONE: abort wins, stay/go IDLE.
- config_out is not cleared between blocks; words overwrite their slices. The COMMIT value is fully defined because every slice is rewritten before each COMMIT.
- WORDS_PER_BLOCK==1: every transfer goes straight to COMMIT.
- Index and word counter widths: $clog2 of their range, minimum 1 bit. No wrap occurs beyond terminal values.

Test Plan:
- Basic load (defaults): start, then words 0x34,0x12,0x78,0x56,0xBC,0x9A,0xF0,0xDE with in_valid=1 continuous. Required:
  - cen=0001 with config_out=0x1234;
  - then cen=0010/0x5678, 0100/0x9ABC, 1000/0xDEF0, each pulse 1 cycle and 1 cycle after its last word;
  - done=1 the cycle after the final COMMIT; in_ready low during each COMMIT.
- Backpressure/gaps: same stream with in_valid toggling 1,0,0,1. Required: identical config_out/cen sequence; no word lost or duplicated; counters hold while in_valid=0.
- Abort mid-block: start, send 0xAA, assert abort. Required: IDLE next cycle, cen never asserted, done=0. A fresh start with 0x34,0x12 yields cen=0001 with 0x1234.
- Reset mid-session: drop rst_n during SHIFT of block 2. Required: all outputs 0 immediately (async), no cen pulse. Load restarts from block 0 after release and start.
- Start handling: start pulses during SHIFT are ignored, with no index reset. Start in DONE restarts at block 0 and clears done. Start+abort together leaves IDLE.
- Parameter corner: NUM_BLOCKS=1, MEM_SIZE=8, WORD_BITS=8. Word 0x5A -> cen=1, config_out=0x5A next cycle, done the cycle after.
